// File: rtl/sirv_gnrl_rrarb_pkg.sv
// sirv_gnrl_rrarb_pkg: state encodings and width helper shared by the round-robin arbiter
package sirv_gnrl_rrarb_pkg;
  typedef enum logic [1:0] {
    RRARB_ST_ARB  = 2'd0,
    RRARB_ST_HOLD = 2'd1,
    RRARB_ST_LOCK = 2'd2
  } rrarb_st_e;
  function automatic int clog2(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sirv_gnrl_rrarb_if.sv
// sirv_gnrl_rrarb_if: N requester channels in, one shared valid/ready channel out
interface sirv_gnrl_rrarb_if import sirv_gnrl_rrarb_pkg::*; #(
  parameter int N  = 4,
  parameter int DW = 32
);
  localparam int IW = clog2(N);
  logic [N-1:0]    i_req_valid;
  logic [N-1:0]    i_req_ready;
  logic [N*DW-1:0] i_req_dat;
  logic [N-1:0]    i_req_last;
  logic            o_valid;
  logic            o_ready;
  logic [DW-1:0]   o_dat;
  logic [IW-1:0]   o_id;
  logic            o_last;
  modport master (
    output i_req_valid, i_req_dat, i_req_last, o_ready,
    input  i_req_ready, o_valid, o_dat, o_id, o_last
  );
  modport slave (
    input  i_req_valid, i_req_dat, i_req_last, o_ready,
    output i_req_ready, o_valid, o_dat, o_id, o_last
  );
endinterface

// File: rtl/sirv_gnrl_dfflr.sv
// sirv_gnrl_dfflr: load-enabled flop, async active-low reset to zero
module sirv_gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rst_n
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) qout <= '0;
    else if (lden) qout <= dnxt;
endmodule

// File: rtl/sirv_gnrl_dfflrs.sv
// sirv_gnrl_dfflrs: load-enabled flop, async active-low reset to ones
module sirv_gnrl_dfflrs #(
  parameter int DW = 1
) (
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rst_n
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) qout <= '1;
    else if (lden) qout <= dnxt;
endmodule

// File: rtl/sirv_gnrl_rr_pick.sv
// sirv_gnrl_rr_pick: first set req bit at or above one-hot ptr, wrapping; onehot0 result
module sirv_gnrl_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] gnt
);
  logic [2*N-1:0] dreq, dgnt;
  assign dreq = {req, req};
  // borrow from ptr clears exactly the first requester at or after ptr in the doubled vector
  assign dgnt = dreq & ~(dreq - {{N{1'b0}}, ptr});
  assign gnt  = dgnt[N-1:0] | dgnt[2*N-1:N];
endmodule

// File: rtl/sirv_gnrl_rrarb.sv
// sirv_gnrl_rrarb: round-robin arbiter with burst lock and stall hold.
// Define SIRV_GNRL_RRARB_OUTREG_EN for a 1-entry registered output stage.
module sirv_gnrl_rrarb import sirv_gnrl_rrarb_pkg::*; #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic clk,
  input  logic rst_n,
  sirv_gnrl_rrarb_if.slave bus
);
  localparam int IW = clog2(N);
  logic [1:0]    st_q;
  rrarb_st_e     st, st_nxt;
  logic [N-1:0]  ptr, ptr_nxt, pick, gnt_q, grant, gv;
  logic          gvalid, glast, chan_rdy, hs;
  logic [DW-1:0] sel_dat;
  logic [IW-1:0] sel_id;
  assign st = rrarb_st_e'(st_q);
  sirv_gnrl_rr_pick #(.N(N)) u_pick (.req(bus.i_req_valid), .ptr(ptr), .gnt(pick));
  assign grant  = (st == RRARB_ST_ARB) ? pick : gnt_q;
  assign gv     = grant & bus.i_req_valid;
  assign gvalid = |gv;
  assign glast  = |(gv & bus.i_req_last);
  assign hs     = gvalid & chan_rdy;
  assign bus.i_req_ready = grant & {N{chan_rdy}};
  always_comb begin
    sel_dat = '0;
    sel_id  = '0;
    ptr_nxt = '0;
    for (int k = 0; k < N; k++) begin
      sel_dat |= {DW{gv[k]}} & bus.i_req_dat[k*DW +: DW];
      sel_id  |= gv[k] ? IW'(k) : '0;
      ptr_nxt[(k+1)%N] = grant[k];
    end
  end
  always_comb begin
    st_nxt = st;
    if (st == RRARB_ST_HOLD)
      st_nxt = hs ? (glast ? RRARB_ST_ARB : RRARB_ST_LOCK) : RRARB_ST_HOLD;
    else if (st == RRARB_ST_LOCK)
      st_nxt = (hs & glast) ? RRARB_ST_ARB : RRARB_ST_LOCK;
    else
      st_nxt = hs ? (glast ? RRARB_ST_ARB : RRARB_ST_LOCK) : (gvalid ? RRARB_ST_HOLD : RRARB_ST_ARB);
  end
  sirv_gnrl_dfflr #(2) u_st (.lden(1'b1), .dnxt(st_nxt), .qout(st_q), .clk, .rst_n);
  sirv_gnrl_dfflr #(N) u_gnt (.lden(st == RRARB_ST_ARB), .dnxt(pick), .qout(gnt_q), .clk, .rst_n);
  // only a finishing beat rotates priority, so a burst owner keeps its slot across the burst
  sirv_gnrl_dfflrs #(1) u_ptr0 (.lden(hs & glast), .dnxt(ptr_nxt[0]), .qout(ptr[0]), .clk, .rst_n);
  sirv_gnrl_dfflr #(N-1) u_ptrh (.lden(hs & glast), .dnxt(ptr_nxt[N-1:1]), .qout(ptr[N-1:1]), .clk, .rst_n);
`ifdef SIRV_GNRL_RRARB_OUTREG_EN
  logic          ovld_q;
  logic [DW+IW:0] oreg_q;
  assign chan_rdy = ~ovld_q | bus.o_ready;
  sirv_gnrl_dfflr #(1) u_ovld (.lden(chan_rdy), .dnxt(gvalid), .qout(ovld_q), .clk, .rst_n);
  sirv_gnrl_dfflr #(DW+IW+1) u_oreg (.lden(chan_rdy), .dnxt({sel_dat, sel_id, glast}), .qout(oreg_q), .clk, .rst_n);
  assign bus.o_valid = ovld_q;
  assign {bus.o_dat, bus.o_id, bus.o_last} = oreg_q;
`else
  assign chan_rdy    = bus.o_ready;
  assign bus.o_valid = gvalid;
  assign bus.o_dat   = sel_dat;
  assign bus.o_id    = sel_id;
  assign bus.o_last  = glast;
`endif
  a_ordy_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(bus.o_ready));
  a_valid_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(bus.i_req_valid));
  a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.i_req_ready));
endmodule
